// File: rtl/axis_neuron_out_if.sv
// AXI-stream handshake bundle carried between the neuron output stage and its consumer.
interface axis_if #(
   parameter int DW = 32
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_neuron_out.sv
// Neuron output stage: bias add, optional ReLU, round/shift/saturate, then a small
// first-word-fall-through FIFO presented as an AXI-stream with tlast per layer.
module axis_neuron_out #(
   parameter int N_NEURONS = 16,
   parameter int OW        = 8,
   parameter int SHIFT     = 8,
   parameter int RELU      = 1,
   parameter int DEPTH     = 4
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [31:0]                  mac_result,
   input  logic                         mac_valid,
   output logic                         mac_hold,
   input  logic                         bias_wr_en,
   input  logic [$clog2(N_NEURONS)-1:0] bias_wr_addr,
   input  logic [31:0]                  bias_wr_data,
   axis_if.master                       axis_out,
   output logic                         overflow,
   output logic                         saturated
);
   localparam int AW = $clog2(N_NEURONS);
   localparam int PW = $clog2(DEPTH);
   localparam logic signed [33:0] MAXV = 34'((2 ** (OW - 1)) - 1);
   localparam logic signed [33:0] MINV = -MAXV - 34'sd1;
   localparam logic signed [33:0] HALF = 34'(2 ** (SHIFT - 1));

   logic [31:0]        bias_mem [N_NEURONS];
   logic [AW-1:0]      idx;
   logic signed [32:0] s1_sum;
   logic               s1_valid;
   logic               s1_last;
   logic [OW-1:0]      s2_data;
   logic               s2_valid;
   logic               s2_last;

   logic signed [33:0] rounded;
   logic signed [33:0] shifted;
   logic               neg_clamp;
   logic               clip_hi;
   logic               clip_lo;

   logic [OW:0]        fifo_mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW:0]        count;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               push;
   logic               hold_next;

   // Bias table is deliberately left out of reset so weights survive a pipeline flush.
   always_ff @(posedge aclk) begin
      if (bias_wr_en) begin
         bias_mem[bias_wr_addr] <= bias_wr_data;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         idx      <= '0;
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= mac_valid;
         if (mac_valid) begin
            s1_sum  <= {mac_result[31], mac_result} + {bias_mem[idx][31], bias_mem[idx]};
            s1_last <= (idx == AW'(N_NEURONS - 1));
            idx     <= (idx == AW'(N_NEURONS - 1)) ? '0 : idx + AW'(1);
         end
      end
   end

   // Adding half an LSB before the arithmetic shift gives round-half-up.
   always_comb begin
      rounded   = {s1_sum[32], s1_sum} + HALF;
      shifted   = rounded >>> SHIFT;
      neg_clamp = (RELU != 0) && s1_sum[32];
      clip_hi   = shifted > MAXV;
      clip_lo   = shifted < MINV;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_last   <= 1'b0;
         saturated <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_last <= s1_last;
            if (neg_clamp) begin
               s2_data <= '0;
            end else if (clip_hi) begin
               s2_data <= MAXV[OW-1:0];
            end else if (clip_lo) begin
               s2_data <= MINV[OW-1:0];
            end else begin
               s2_data <= shifted[OW-1:0];
            end
            if (!neg_clamp && (clip_hi || clip_lo)) begin
               saturated <= 1'b1;
            end
         end
      end
   end

   // A full FIFO still accepts a push when the head is leaving in the same cycle.
   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == (PW + 1)'(DEPTH));
      pop        = !fifo_empty && axis_out.tready;
      push       = s2_valid && (!fifo_full || pop);
      hold_next  = (int'(count) + int'(s1_valid) + int'(s2_valid)) > (DEPTH - 3);
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {s2_last, s2_data};
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         mac_hold <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + (PW + 1)'(1);
         end else if (!push && pop) begin
            count <= count - (PW + 1)'(1);
         end
         if (s2_valid && !push) begin
            overflow <= 1'b1;
         end
         mac_hold <= hold_next;
      end
   end

   always_comb begin
      axis_out.tvalid = !fifo_empty;
      axis_out.tdata  = '0;
      axis_out.tlast  = 1'b0;
      if (!fifo_empty) begin
         axis_out.tdata[OW-1:0] = fifo_mem[rd_ptr][OW-1:0];
         axis_out.tlast         = fifo_mem[rd_ptr][OW];
      end
   end
endmodule
